pass_rom_arbiter: RTL and testbench

Shares the single 8-word password ROM between two requesters: the password-entry checker (port 0) and the admin/display unit (port 1). Each requester posts an address; the block grants one at a time, drives the ROM address, waits the ROM read latency, and returns the 20-bit word with a per-requester valid pulse. It replaces direct ROM wiring so that more than one block can read passwords without address contention.

---
 rtl/pass_rom_arbiter.sv | 151 +++++++++++++++
 tb/tb_pass_rom_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pass_rom_arbiter.sv
// pass_rom_arbiter
//   Shares one password ROM between two requesters. A request is granted for
//   one cycle, its address is registered onto rom_address, and after ROM_LAT
//   edges the ROM word is captured into rdata with a one-cycle rvalid pulse
//   to the granted port.
//
//   Configuration macro: PASS_ARB_RR_EN
//     defined   -> round-robin on a tie (port not served last wins)
//     undefined -> fixed priority, port 0 wins a tie
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req0/addr0        requester 0 (password-entry checker)
//   req1/addr1        requester 1 (admin/display unit)
//   gnt0/gnt1         one-cycle grant pulses
//   rvalid0/rvalid1   one-cycle data-valid pulses
//   rdata             captured ROM word (shared)
//   busy              high while a read is in flight
//   rom_address       ROM address output
//   rom_q             ROM data input
module pass_rom_arbiter #(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DATA_W  = 20,
  parameter int unsigned ROM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [2:0] LAT_INIT = 3'(ROM_LAT);

  logic [0:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              port_q, port_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              win1;

`ifdef PASS_ARB_RR_EN
  logic last_q, last_d;

  // On a tie the port not served last wins; last_q resets to 1 so port 0
  // takes the first tie.
  always_comb begin
    win1 = req1 & (~req0 | ~last_q);
  end
`else
  always_comb begin
    win1 = req1 & ~req0;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    port_d    = port_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
`ifdef PASS_ARB_RR_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          addr_d  = win1 ? addr1 : addr0;
          gnt0_d  = ~win1;
          gnt1_d  = win1;
          port_d  = win1;
          cnt_d   = LAT_INIT;
          state_d = WAIT;
`ifdef PASS_ARB_RR_EN
          last_d  = win1;
`endif
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        // cnt_q==1 marks the edge where rom_q has settled for addr_q.
        if (cnt_q == 3'd1) begin
          rdata_d   = rom_q;
          rvalid0_d = ~port_q;
          rvalid1_d = port_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      port_q    <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
`ifdef PASS_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      port_q    <= port_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
`ifdef PASS_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign rdata       = rdata_q;
  assign rom_address = addr_q;
  assign busy        = (state_q == WAIT);

endmodule

// File: tb/tb_pass_rom_arbiter.sv
// Testbench for pass_rom_arbiter: directed vectors, expected grants and
// read data pushed to queues at issue time, compared by a negedge monitor.
module tb_pass_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [2:0]  addr0, addr1;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [19:0] rdata;
  logic [2:0]  rom_address;
  logic [19:0] rom_q = '0;

  logic [19:0] rom_mem [8];

  typedef struct {
    bit          port;
    logic [19:0] val;
  } exp_t;

  exp_t gq[$];   // expected grants: port + address
  exp_t dq[$];   // expected read data: port + word

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pass_rom_arbiter #(.ADDR_W(3), .DATA_W(20), .ROM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy), .rom_address(rom_address), .rom_q(rom_q)
  );

  // ROM with one register stage: address registered at E, rom_q valid at E+2.
  always @(posedge clk) rom_q <= rom_mem[rom_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (gnt0 && gnt1) fail_now("gnt_both_high");
    else if (gnt0 || gnt1) begin
      if (gq.size() == 0) fail_now("gnt_unexpected");
      else begin
        e = gq.pop_front();
        check("gnt_port", {31'd0, gnt1}, {31'd0, e.port});
        check("gnt_addr", {29'd0, rom_address}, {12'd0, e.val});
      end
    end
    if (rvalid0 && rvalid1) fail_now("rvalid_both_high");
    else if (rvalid0 || rvalid1) begin
      if (dq.size() == 0) fail_now("rvalid_unexpected");
      else begin
        e = dq.pop_front();
        check("rvalid_port", {31'd0, rvalid1}, {31'd0, e.port});
        check("rdata", {12'd0, rdata}, {12'd0, e.val});
      end
    end
    if ((gnt0 && rvalid0) || (gnt1 && rvalid1)) fail_now("gnt_rvalid_overlap");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit port, output int n);
    bit seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      tick();
      n++;
      seen = port ? gnt1 : gnt0;
    end
    if (!seen) fail_now("gnt_timeout");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    if (busy) fail_now("idle_timeout");
  endtask

  task automatic do_read(input bit port, input logic [2:0] a);
    int n;
    gq.push_back('{port: port, val: {17'd0, a}});
    dq.push_back('{port: port, val: rom_mem[a]});
    if (port) begin req1 = 1'b1; addr1 = a; end
    else      begin req0 = 1'b1; addr0 = a; end
    wait_gnt(port, n);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    wait_idle();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, prev, cyc, ng;
    rom_mem[0] = 20'h0A5C3; rom_mem[1] = 20'h1B7E4;
    rom_mem[2] = 20'h2C901; rom_mem[3] = 20'h12345;
    rom_mem[4] = 20'h4D2F6; rom_mem[5] = 20'h5E0A7;
    rom_mem[6] = 20'h6F318; rom_mem[7] = 20'h70ABC;

    // Reset with requests active
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = 3'd3; addr1 = 3'd5;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_outs", {26'd0, gnt0, gnt1, rvalid0, rvalid1, busy, 1'b0}, 32'd0);
      check("rst_rom_address", {29'd0, rom_address}, 32'd0);
      check("rst_rdata", {12'd0, rdata}, 32'd0);
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();
    check("post_rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // Single read: port 0, address 3
    gq.push_back('{port: 1'b0, val: 20'd3});
    dq.push_back('{port: 1'b0, val: 20'h12345});
    req0 = 1'b1; addr0 = 3'd3;
    wait_gnt(1'b0, n);
    req0 = 1'b0;
    check("single_gnt_latency", n, 1);
    check("single_rom_address", {29'd0, rom_address}, 32'd3);
    check("single_busy", {31'd0, busy}, 32'd1);
    tick();
    check("single_rvalid_early", {30'd0, rvalid0, rvalid1}, 32'd0);
    tick();
    check("single_rvalid0", {31'd0, rvalid0}, 32'd1);
    check("single_rvalid1", {31'd0, rvalid1}, 32'd0);
    check("single_rdata", {12'd0, rdata}, 32'h12345);
    tick();
    check("single_idle", {31'd0, busy}, 32'd0);
    check("single_rdata_hold", {12'd0, rdata}, 32'h12345);

    // Contention: both held, addr0=1, addr1=5
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
`ifdef PASS_ARB_RR_EN
      bit p = (i % 2) == 1;
`else
      bit p = 1'b0;
`endif
      gq.push_back('{port: p, val: p ? 20'd5 : 20'd1});
      dq.push_back('{port: p, val: p ? 20'h5E0A7 : 20'h1B7E4});
    end
    req0 = 1'b1; addr0 = 3'd1; req1 = 1'b1; addr1 = 3'd5;
    prev = 0; cyc = 0; ng = 0;
    while (ng < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (gnt0 || gnt1) begin
        if (ng > 0) check("contention_gap", cyc - prev, 3);
        prev = cyc;
        ng++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("contention_grants", ng, 4);
    tick();
    wait_idle();

    // Late request raised while busy
    gq.push_back('{port: 1'b0, val: 20'd4});
    dq.push_back('{port: 1'b0, val: 20'h4D2F6});
    gq.push_back('{port: 1'b1, val: 20'd6});
    dq.push_back('{port: 1'b1, val: 20'h6F318});
    req0 = 1'b1; addr0 = 3'd4;
    wait_gnt(1'b0, n);
    req0 = 1'b0;
    tick();
    check("late_busy", {31'd0, busy}, 32'd1);
    req1 = 1'b1; addr1 = 3'd6;
    wait_gnt(1'b1, n);
    req1 = 1'b0;
    check("late_gnt1_delay", n + 1, 3);
    tick();
    wait_idle();

    // Reset mid-read
    gq.push_back('{port: 1'b0, val: 20'd7});
    req0 = 1'b1; addr0 = 3'd7;
    wait_gnt(1'b0, n);
    req0 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
    repeat (3) tick();
    check("midrst_no_rvalid_pending", dq.size(), 0);
    do_read(1'b1, 3'd2);

    // Sweep port 1 over all addresses
    for (int i = 0; i < 8; i++) do_read(1'b1, 3'(i));

    repeat (5) tick();
    check("gnt_queue_drained", gq.size(), 0);
    check("data_queue_drained", dq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
